// File: rtl/mfp_ahb_pkg.sv
// Shared AHB-Lite codes and FSM encoding for the wait-state RAM slave.
package mfp_ahb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned WCNT_W = 4;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_LAST = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

endpackage

// File: rtl/mfp_ram_be.sv
// Word-organised storage with asynchronous read and per-byte-lane synchronous write.
module mfp_ram_be
  import mfp_ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                    clk_i,
  input  logic                    we_i,
  input  logic [LANES-1:0]        be_i,
  input  logic [ADDR_WIDTH-3:0]   waddr_i,
  input  logic [DATA_W-1:0]       wdata_i,
  input  logic [ADDR_WIDTH-3:0]   raddr_i,
  output logic [DATA_W-1:0]       rdata_o
);

  localparam int unsigned DEPTH = 2 ** (ADDR_WIDTH - 2);

  logic [DATA_W-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[raddr_i];

  // Contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < int'(LANES); l++) begin
      if (we_i && be_i[l]) begin
        mem_q[waddr_i][8*l +: 8] <= wdata_i[8*l +: 8];
      end
    end
  end

endmodule

// File: rtl/mfp_ahb_ram_wait.sv
// AHB-Lite RAM slave with a fixed number of wait states per OKAY data phase
// and a two-cycle ERROR response for misaligned or oversized transfers.
module mfp_ahb_ram_wait
  import mfp_ahb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [31:0]       HADDR,
  input  logic [2:0]        HBURST,
  input  logic              HMASTLOCK,
  input  logic [3:0]        HPROT,
  input  logic              HSEL,
  input  logic [2:0]        HSIZE,
  input  logic [1:0]        HTRANS,
  input  logic [31:0]       HWDATA,
  input  logic              HWRITE,
  input  logic              HREADY,
  output logic [31:0]       HRDATA,
  output logic              HREADYOUT,
  output logic              HRESP,
  input  logic              SI_Endian
);

  localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
  localparam logic [WCNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;

  state_e                  state_q, state_d;
  logic [WCNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [2:0]              size_q, size_d;
  logic                    write_q, write_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    hready_q, hready_d;
  logic                    hresp_q, hresp_d;

  logic                    accept_c;
  logic                    illegal_c;
  logic                    wr_en_c;
  logic [LANES-1:0]        be_c;
  logic [WORD_AW-1:0]      rd_word_c;
  logic                    rd_is_read_c;
  logic [DATA_W-1:0]       mem_rdata_c;
  logic                    unused_c;

  assign unused_c = ^{HBURST, HMASTLOCK, HPROT, SI_Endian,
                      HADDR[31:ADDR_WIDTH], HTRANS[0]};

  // Address phases are only taken when this slave is not stalling the bus.
  assign accept_c = HSEL && HTRANS[1] && HREADY && !HRESET &&
                    (state_q == ST_IDLE || state_q == ST_LAST || state_q == ST_ERR2);

  assign illegal_c = (HSIZE > HSIZE_WORD) ||
                     ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                     ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));

  assign wr_en_c = (state_q == ST_LAST) && write_q && !HRESET;

  always_comb begin
    be_c = 4'b1111;
    case (size_q)
      HSIZE_BYTE: be_c = 4'b0001 << addr_q[1:0];
      HSIZE_HALF: be_c = addr_q[1] ? 4'b1100 : 4'b0011;
      default:    be_c = 4'b1111;
    endcase
  end

  // Read address comes from the held address after waits, else straight off the bus.
  assign rd_word_c    = (state_q == ST_WAIT) ? addr_q[ADDR_WIDTH-1:2] : HADDR[ADDR_WIDTH-1:2];
  assign rd_is_read_c = (state_q == ST_WAIT) ? !write_q : !HWRITE;

  mfp_ram_be #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk_i   (HCLK),
    .we_i    (wr_en_c),
    .be_i    (be_c),
    .waddr_i (addr_q[ADDR_WIDTH-1:2]),
    .wdata_i (HWDATA),
    .raddr_i (rd_word_c),
    .rdata_o (mem_rdata_c)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    size_d   = size_q;
    write_d  = write_q;
    rdata_d  = rdata_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_LAST;
        else             cnt_d   = cnt_q - WCNT_W'(1);
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (accept_c) begin
          addr_d  = HADDR[ADDR_WIDTH-1:0];
          size_d  = HSIZE;
          write_d = HWRITE;
          if (illegal_c) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LOAD;
          end else begin
            state_d = ST_LAST;
          end
        end
      end
    endcase

    // A write committing on the same edge forwards its enabled lanes into the read.
    if (state_d == ST_LAST && rd_is_read_c) begin
      for (int l = 0; l < int'(LANES); l++) begin
        if (wr_en_c && be_c[l] && (addr_q[ADDR_WIDTH-1:2] == rd_word_c))
          rdata_d[8*l +: 8] = HWDATA[8*l +: 8];
        else
          rdata_d[8*l +: 8] = mem_rdata_c[8*l +: 8];
      end
    end

    hready_d = !(state_d == ST_WAIT || state_d == ST_ERR1);
    hresp_d  = (state_d == ST_ERR1 || state_d == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
      hready_q <= 1'b1;
      hresp_q  <= HRESP_OKAY;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      write_q  <= write_d;
      rdata_q  <= rdata_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  assign HRDATA    = rdata_q;
  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;

endmodule

// File: tb/tb_mfp_ahb_ram_wait.sv
// Scoreboard bench: a WAIT_STATES=2 slave and a zero-wait slave share one master.
module tb_mfp_ahb_ram_wait;

  localparam int unsigned WS_A = 2;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HMASTLOCK;
  logic [3:0]  HPROT;
  logic        sel2, sel0;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        SI_Endian;
  logic [31:0] rdata2, rdata0;
  logic        rdy2, rdy0, resp2, resp0;

  always #5 HCLK = ~HCLK;

  mfp_ahb_ram_wait #(.ADDR_WIDTH(6), .WAIT_STATES(WS_A)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HBURST(HBURST),
    .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSEL(sel2), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE), .HREADY(rdy2),
    .HRDATA(rdata2), .HREADYOUT(rdy2), .HRESP(resp2), .SI_Endian(SI_Endian)
  );

  mfp_ahb_ram_wait #(.ADDR_WIDTH(6), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HBURST(HBURST),
    .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSEL(sel0), .HSIZE(HSIZE),
    .HTRANS(HTRANS), .HWDATA(HWDATA), .HWRITE(HWRITE), .HREADY(rdy0),
    .HRDATA(rdata0), .HREADYOUT(rdy0), .HRESP(resp0), .SI_Endian(SI_Endian)
  );

  // kind: 0 transfer, 1 selected IDLE, 2 unselected NONSEQ
  typedef struct {
    bit          to0;
    int          kind;
    bit          write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    bit          write;
    logic        resp;
    int          low;
    logic [31:0] rdata;
  } exp_t;

  cmd_t        cmd_q[$];
  exp_t        exp_q[$];
  logic [31:0] m2 [16];
  logic [31:0] m0 [16];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_bad(input logic [2:0] size, input logic [31:0] addr);
    return (size > 3'd2) || (size == 3'd1 && addr[0]) ||
           (size == 3'd2 && addr[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] apply_wr(input logic [31:0] old, input logic [2:0] size,
                                           input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    for (int l = 0; l < 4; l++) begin
      if ((size == 3'd2) || (size == 3'd1 && (l / 2) == int'(addr[1])) ||
          (size == 3'd0 && l == int'(addr[1:0])))
        r[8*l +: 8] = wd[8*l +: 8];
    end
    return r;
  endfunction

  task automatic q(input bit to0, input int kind, input bit write, input logic [31:0] addr,
                   input logic [2:0] size, input logic [31:0] wdata);
    cmd_t c;
    c.to0 = to0; c.kind = kind; c.write = write; c.addr = addr; c.size = size; c.wdata = wdata;
    cmd_q.push_back(c);
  endtask

  task automatic drive_idle();
    sel2 = 1'b0; sel0 = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic run_queue();
    cmd_t ap, dp, c;
    exp_t e;
    bit   ap_v = 0, dp_v = 0, can_issue, rdy, resp;
    int   low = 0, budget = 0, idx;
    logic [31:0] rd;
    while ((cmd_q.size() > 0 || ap_v || dp_v) && budget < 500) begin
      @(posedge HCLK); #1;
      budget++;
      if (ap_v) begin
        dp = ap; dp_v = 1; ap_v = 0; low = 0; HWDATA = dp.wdata;
      end
      can_issue = 1;
      if (dp_v) begin
        rdy  = dp.to0 ? rdy0 : rdy2;
        resp = dp.to0 ? resp0 : resp2;
        rd   = dp.to0 ? rdata0 : rdata2;
        if (!rdy) begin
          low++;
          can_issue = 0;
          check_eq("stall_resp", 32'(resp), 32'(exp_q[0].resp));
        end else begin
          e = exp_q.pop_front();
          check_eq("resp", 32'(resp), 32'(e.resp));
          check_eq("wait_cycles", 32'(low), 32'(e.low));
          if (!e.write && !e.resp) check_eq("rdata", rd, e.rdata);
          dp_v = 0;
        end
      end else begin
        check_eq("idle_ready", {28'd0, rdy2, rdy0, resp2, resp0}, 32'hC);
      end
      drive_idle();
      if (can_issue && cmd_q.size() > 0) begin
        c = cmd_q.pop_front();
        HADDR = c.addr; HSIZE = c.size;
        case (c.kind)
          0: begin
            sel2 = !c.to0; sel0 = c.to0; HTRANS = 2'b10; HWRITE = c.write;
            idx = int'(c.addr[5:2]);
            e.write = c.write;
            e.resp  = is_bad(c.size, c.addr);
            e.low   = e.resp ? 1 : (c.to0 ? 0 : int'(WS_A));
            if (!e.resp && c.write) begin
              if (c.to0) m0[idx] = apply_wr(m0[idx], c.size, c.addr, c.wdata);
              else       m2[idx] = apply_wr(m2[idx], c.size, c.addr, c.wdata);
            end
            e.rdata = c.to0 ? m0[idx] : m2[idx];
            exp_q.push_back(e);
            ap = c; ap_v = 1;
          end
          1: begin
            sel2 = !c.to0; sel0 = c.to0; HTRANS = 2'b00; HWRITE = 1'b1;
          end
          default: begin
            HTRANS = 2'b10; HWRITE = 1'b1;
          end
        endcase
      end
    end
    if (budget >= 500) check_eq("timeout", 32'd1, 32'd0);
    drive_idle();
  endtask

  initial begin
    HRESET = 1'b1; HADDR = '0; HBURST = '0; HMASTLOCK = 1'b0; HPROT = '0;
    HSIZE = 3'd2; HWDATA = '0; SI_Endian = 1'b0;
    drive_idle();
    repeat (3) @(posedge HCLK);
    #1;
    check_eq("rst_state2", {rdy2, resp2, 30'd0}, 32'h8000_0000);
    check_eq("rst_rdata2", rdata2, 32'd0);
    check_eq("rst_state0", {rdy0, resp0, 30'd0}, 32'h8000_0000);
    HRESET = 1'b0;

    // Slow slave: basic word, lane writes, errors, idle/unselected, aliasing.
    q(0, 0, 1, 32'h10, 3'd2, 32'hDEADBEEF);
    q(0, 0, 0, 32'h10, 3'd2, 32'h0);
    q(0, 0, 1, 32'h20, 3'd2, 32'h0);
    q(0, 0, 1, 32'h21, 3'd0, 32'h0000AA00);
    q(0, 0, 1, 32'h22, 3'd1, 32'h55660000);
    q(0, 0, 0, 32'h20, 3'd2, 32'h0);
    q(0, 0, 1, 32'h00, 3'd2, 32'hCAFEF00D);
    q(0, 0, 0, 32'h03, 3'd1, 32'h0);
    q(0, 0, 1, 32'h02, 3'd2, 32'hFFFFFFFF);
    q(0, 0, 0, 32'h00, 3'd3, 32'h0);
    q(0, 0, 0, 32'h00, 3'd2, 32'h0);
    q(0, 0, 1, 32'h30, 3'd2, 32'h0BADC0DE);
    q(0, 1, 1, 32'h30, 3'd2, 32'h0);
    q(0, 2, 1, 32'h30, 3'd2, 32'h0);
    q(0, 0, 0, 32'h30, 3'd2, 32'h0);
    q(0, 0, 1, 32'h64, 3'd2, 32'h600D600D);
    q(0, 0, 0, 32'h24, 3'd2, 32'h0);
    q(0, 0, 1, 32'h08, 3'd2, 32'h11111111);
    q(0, 0, 0, 32'h08, 3'd2, 32'h0);
    // Zero-wait slave: back-to-back write/read with full and partial forwarding.
    q(1, 0, 1, 32'h04, 3'd2, 32'h12345678);
    q(1, 0, 0, 32'h04, 3'd2, 32'h0);
    q(1, 0, 1, 32'h0C, 3'd2, 32'h0);
    q(1, 0, 1, 32'h0D, 3'd0, 32'h0000AB00);
    q(1, 0, 0, 32'h0C, 3'd2, 32'h0);
    q(1, 0, 0, 32'h06, 3'd1, 32'h0);
    q(1, 0, 0, 32'h05, 3'd2, 32'h0);
    q(1, 0, 0, 32'h04, 3'd2, 32'h0);
    run_queue();

    // Reset in the middle of a stalled write must drop that write.
    @(posedge HCLK); #1;
    sel2 = 1'b1; HTRANS = 2'b10; HADDR = 32'h08; HSIZE = 3'd2; HWRITE = 1'b1;
    @(posedge HCLK); #1;
    drive_idle();
    HWDATA = 32'h22222222;
    check_eq("rst_in_wait", 32'(rdy2), 32'd0);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    check_eq("rst_mid_ready", 32'(rdy2), 32'd1);
    check_eq("rst_mid_resp", 32'(resp2), 32'd0);
    check_eq("rst_mid_rdata", rdata2, 32'd0);
    HRESET = 1'b0;
    q(0, 0, 0, 32'h08, 3'd2, 32'h0);
    q(0, 0, 0, 32'h10, 3'd2, 32'h0);
    run_queue();

    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
